// File: rtl/rr_mux_reg.sv
// N-to-1 valid/ready multiplexer with a single registered output stage.
// Channel choice is either a fixed select or round-robin among valid inputs.
module rr_mux_reg #(
    parameter int  N     = 8,
    parameter int  WIDTH = 8,
    localparam int SEL_W = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SEL_W-1:0]   out_chan
);

    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [SEL_W-1:0] r_out_chan;
    logic [SEL_W-1:0] r_rr_ptr;

    logic             w_load_en;
    logic             w_found;
    logic [SEL_W-1:0] w_grant;
    logic [N-1:0]     w_ready;
    logic             w_xfer;
    logic [WIDTH-1:0] w_data;
    logic [SEL_W-1:0] w_chan;

    assign w_load_en = !r_out_valid || out_ready;

    // Search starts one past the last granted channel and wraps.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 1; k <= N; k++) begin
            if (!w_found && in_valid[(int'(r_rr_ptr) + k) % N]) begin
                w_found = 1'b1;
                w_grant = SEL_W'((int'(r_rr_ptr) + k) % N);
            end
        end
    end

    // An out-of-range sel matches no channel, so nothing is offered.
    always_comb begin
        w_ready = '0;
        if (rst_n && w_load_en) begin
            for (int i = 0; i < N; i++) begin
                if (mode) begin
                    if (w_found && int'(w_grant) == i) w_ready[i] = 1'b1;
                end else begin
                    if (int'(sel) == i) w_ready[i] = 1'b1;
                end
            end
        end
    end

    assign w_xfer = |(w_ready & in_valid);

    always_comb begin
        w_data = '0;
        w_chan = '0;
        for (int i = 0; i < N; i++) begin
            if (w_ready[i]) begin
                w_data = in_data[i*WIDTH +: WIDTH];
                w_chan = SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_chan  <= '0;
            r_rr_ptr    <= SEL_W'(N - 1);
        end else if (w_load_en) begin
            if (w_xfer) begin
                r_out_data  <= w_data;
                r_out_chan  <= w_chan;
                r_out_valid <= 1'b1;
                if (mode) r_rr_ptr <= w_chan;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_chan  = r_out_chan;

endmodule

// File: tb/tb_rr_mux_reg.sv
// Scoreboard bench for rr_mux_reg: an 8-channel and a 6-channel instance share
// stimulus; a reference model predicts ready, valid and the words delivered.
module tb_rr_mux_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mode;
    logic [2:0]  sel;
    logic [63:0] in_data;
    logic [7:0]  in_valid;
    logic        out_ready;

    logic [7:0]  rdy8;
    logic [7:0]  od8;
    logic        ov8;
    logic [2:0]  oc8;
    logic [5:0]  rdy6;
    logic [7:0]  od6;
    logic        ov6;
    logic [2:0]  oc6;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rr_mux_reg #(.N(8), .WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rdy8),
        .out_data(od8), .out_valid(ov8), .out_ready(out_ready), .out_chan(oc8)
    );

    rr_mux_reg #(.N(6), .WIDTH(8)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data[47:0]), .in_valid(in_valid[5:0]), .in_ready(rdy6),
        .out_data(od6), .out_valid(ov6), .out_ready(out_ready), .out_chan(oc6)
    );

    typedef struct {
        logic [7:0] d;
        int         c;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   nch[2]    = '{8, 6};
    int   m_ptr[2]  = '{7, 5};
    bit   m_full[2] = '{1'b0, 1'b0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] vmask(input int d);
        return (d == 0) ? in_valid : (in_valid & 8'h3f);
    endfunction

    function automatic int grant_of(input int d);
        logic [7:0] v;
        int c;
        v = vmask(d);
        for (int k = 1; k <= nch[d]; k++) begin
            c = (m_ptr[d] + k) % nch[d];
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [7:0] exp_ready(input int d);
        logic [7:0] r;
        int g;
        r = 8'h00;
        if (rst_n !== 1'b1) return r;
        if (m_full[d] && !out_ready) return r;
        if (!mode) begin
            if (int'(sel) < nch[d]) r[sel] = 1'b1;
        end else begin
            g = grant_of(d);
            if (g >= 0) r[g] = 1'b1;
        end
        return r;
    endfunction

    // Reference model: advances at each edge using the inputs held across it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ptr  = '{7, 5};
            m_full = '{1'b0, 1'b0};
            q0.delete();
            q1.delete();
        end else begin
            for (int d = 0; d < 2; d++) begin
                logic [7:0] x;
                exp_t e;
                x = exp_ready(d) & vmask(d);
                if (!m_full[d] || out_ready) begin
                    if (x != 8'h00) begin
                        e.c = 0;
                        for (int i = 0; i < 8; i++) if (x[i]) e.c = i;
                        e.d = in_data[e.c*8 +: 8];
                        if (d == 0) q0.push_back(e); else q1.push_back(e);
                        if (mode) m_ptr[d] = e.c;
                        m_full[d] = 1'b1;
                    end else begin
                        m_full[d] = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: per-cycle handshake checks, scoreboard pop on each consumed word.
    always @(negedge clk) begin
        exp_t e;
        chk("ready8", {24'b0, rdy8}, {24'b0, exp_ready(0)});
        chk("ready6", {26'b0, rdy6}, {24'b0, exp_ready(1)});
        chk("valid8", {31'b0, ov8}, {31'b0, m_full[0]});
        chk("valid6", {31'b0, ov6}, {31'b0, m_full[1]});
        if (ov8 && out_ready) begin
            if (q0.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb8_word: got %0h, expected no word", od8);
            end else begin
                e = q0.pop_front();
                chk("sb8_data", {24'b0, od8}, {24'b0, e.d});
                chk("sb8_chan", {29'b0, oc8}, 32'(e.c));
            end
        end
        if (ov6 && out_ready) begin
            if (q1.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb6_word: got %0h, expected no word", od6);
            end else begin
                e = q1.pop_front();
                chk("sb6_data", {24'b0, od6}, {24'b0, e.d});
                chk("sb6_chan", {29'b0, oc6}, 32'(e.c));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic onehot_data();
        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'(1 << i);
    endtask

    initial begin
        bit got;
        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = 3'd0;
        in_valid  = 8'h00;
        out_ready = 1'b1;
        onehot_data();
        cyc(2);
        rst_n = 1'b1;

        // Fixed select on channel 3
        mode = 1'b0; sel = 3'd3; in_valid = 8'hff;
        cyc(2);
        chk("fixed_data", {24'b0, od8}, 32'h08);
        chk("fixed_chan", {29'b0, oc8}, 32'd3);
        chk("fixed_ready", {24'b0, rdy8}, 32'h08);
        cyc(8);

        // Round-robin, all valid, then sparse
        mode = 1'b1;
        cyc(12);
        in_valid = 8'b0010_0100;
        cyc(8);
        in_valid = 8'b0000_0100;
        cyc(4);

        // Backpressure once channel 4 is in the output register
        in_valid = 8'hff;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cyc(1);
            if (ov8 && oc8 == 3'd4) got = 1'b1;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL bp_wait: got no channel 4 load, expected one within 20 cycles");
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            chk("bp_hold_data", {24'b0, od8}, 32'h10);
            chk("bp_hold_ready", {24'b0, rdy8}, 32'h0);
        end
        out_ready = 1'b1;
        cyc(1);
        chk("bp_next_chan", {29'b0, oc8}, 32'd5);
        cyc(3);

        // Out-of-range select on the 6-channel build, then back to round-robin
        mode = 1'b0; sel = 3'd7;
        cyc(2);
        chk("badsel_ready6", {26'b0, rdy6}, 32'h0);
        chk("badsel_valid6", {31'b0, ov6}, 32'd0);
        mode = 1'b1;
        cyc(6);

        // Asynchronous reset while a word is held
        cyc(1);
        chk("pre_rst_valid", {31'b0, ov8}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'b0, ov8}, 32'd0);
        chk("rst_data", {24'b0, od8}, 32'h0);
        chk("rst_chan", {29'b0, oc8}, 32'd0);
        chk("rst_ready", {24'b0, rdy8}, 32'h0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        chk("rst_first_chan", {29'b0, oc8}, 32'd0);
        chk("rst_first_valid", {31'b0, ov8}, 32'd1);
        cyc(4);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = 8'($urandom);
            mode      = 1'($urandom_range(0, 1));
            sel       = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            cyc(1);
        end

        in_valid  = 8'h00;
        out_ready = 1'b1;
        cyc(3);
        chk("drain8", 32'(q0.size()), 32'd0);
        chk("drain6", 32'(q1.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
